// File: rtl/snn_stream_pkg.sv
// Shared types and sizing helpers for the spike-vector serializer.
package snn_stream_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Data beats needed to carry n_spikes bits over the given number of lanes
  function automatic int unsigned calc_beats(input int unsigned n_spikes,
                                             input int unsigned lanes);
    return (n_spikes + lanes - 1) / lanes;
  endfunction

  // Counter width able to index 0..n-1 (never narrower than one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/snn_beat_timer.sv
// Restartable DIV-cycle hold timer; beat_done_o is high during the last cycle of each beat.
module snn_beat_timer
  import snn_stream_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic restart_i,
  output logic beat_done_o
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // done is registered one cycle ahead so it lines up with the final hold cycle
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : CW'(cnt_q + 1'b1);
    end
    done_d = (restart_i || en_i) && (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign beat_done_o = done_q;

endmodule

// File: rtl/snn_spike_streamer.sv
// Serializes each qualified spike vector over LANES pins as a framed beat sequence.
// Optional trailing even-parity beat per lane when SNN_STREAM_PARITY_EN is defined.
module snn_spike_streamer
  import snn_stream_pkg::*;
#(
  parameter int unsigned N_SPIKES = 8,
  parameter int unsigned LANES    = 2,
  parameter int unsigned DIV      = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_SPIKES-1:0] spikes_in,
  input  logic                spikes_valid,
  output logic [LANES-1:0]    lane_out,
  output logic                frame_sync,
  output logic                busy,
  output logic [7:0]          drop_count
);

  localparam int unsigned BEATS = calc_beats(N_SPIKES, LANES);
  localparam int unsigned SR_W  = BEATS * LANES;
`ifdef SNN_STREAM_PARITY_EN
  localparam int unsigned TOTAL_BEATS = BEATS + 1;
`else
  localparam int unsigned TOTAL_BEATS = BEATS;
`endif
  localparam int unsigned BW = cnt_width(TOTAL_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(TOTAL_BEATS - 1);

  state_e                state_q, state_d;
  logic [SR_W-1:0]       sr_q, sr_d;
  logic [N_SPIKES-1:0]   pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [LANES-1:0]      lane_q, lane_d;
  logic                  fs_q, fs_d;
  logic                  busy_q, busy_d;
  logic [7:0]            drop_q, drop_d;
`ifdef SNN_STREAM_PARITY_EN
  logic [LANES-1:0]      par_q, par_d;
`endif

  logic                  beat_done;
  logic                  last_c;
  logic                  start_c;
  logic [N_SPIKES-1:0]   load_vec_c;
  logic [SR_W-1:0]       load_full_c;

  snn_beat_timer #(.DIV(DIV)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       ((state_d == SEND) && !start_c),
    .restart_i  (start_c),
    .beat_done_o(beat_done)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    beat_d      = beat_q;
    lane_d      = lane_q;
    fs_d        = fs_q;
    busy_d      = busy_q;
    drop_d      = drop_q;
`ifdef SNN_STREAM_PARITY_EN
    par_d       = par_q;
`endif
    start_c     = 1'b0;
    load_vec_c  = spikes_in;
    last_c      = beat_done && (beat_q == LAST_BEAT);

    case (state_q)
      IDLE: begin
        if (spikes_valid) begin
          start_c = 1'b1;
        end
      end
      SEND: begin
        if (last_c) begin
          // Frame boundary: pending vector goes first, an arriving one takes its slot
          if (pend_vld_q) begin
            start_c    = 1'b1;
            load_vec_c = pend_q;
            pend_vld_d = spikes_valid;
            if (spikes_valid) begin
              pend_d = spikes_in;
            end
          end else if (spikes_valid) begin
            start_c = 1'b1;
          end else begin
            state_d = IDLE;
            sr_d    = '0;
            beat_d  = '0;
            lane_d  = '0;
            fs_d    = 1'b0;
            busy_d  = 1'b0;
          end
        end else begin
          if (spikes_valid) begin
            if (!pend_vld_q) begin
              pend_d     = spikes_in;
              pend_vld_d = 1'b1;
            end else if (drop_q != 8'hFF) begin
              drop_d = 8'(drop_q + 8'd1);
            end
          end
          if (beat_done) begin
            beat_d = BW'(beat_q + 1'b1);
            fs_d   = 1'b0;
`ifdef SNN_STREAM_PARITY_EN
            if (beat_q == BW'(BEATS - 1)) begin
              lane_d = par_q;
            end else begin
              lane_d = sr_q[LANES-1:0];
              sr_d   = sr_q >> LANES;
              par_d  = par_q ^ sr_q[LANES-1:0];
            end
`else
            lane_d = sr_q[LANES-1:0];
            sr_d   = sr_q >> LANES;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    load_full_c = SR_W'(load_vec_c);
    if (start_c) begin
      state_d = SEND;
      lane_d  = load_full_c[LANES-1:0];
      sr_d    = load_full_c >> LANES;
      beat_d  = '0;
      fs_d    = 1'b1;
      busy_d  = 1'b1;
`ifdef SNN_STREAM_PARITY_EN
      par_d   = load_full_c[LANES-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      beat_q     <= '0;
      lane_q     <= '0;
      fs_q       <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= '0;
`ifdef SNN_STREAM_PARITY_EN
      par_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      beat_q     <= beat_d;
      lane_q     <= lane_d;
      fs_q       <= fs_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
`ifdef SNN_STREAM_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign lane_out   = lane_q;
  assign frame_sync = fs_q;
  assign busy       = busy_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_snn_spike_streamer.sv
// Directed self-checking bench: three instances (8/2/1, 5/2/1 padding, 8/2/3 hold).
module tb_snn_spike_streamer;

`ifdef SNN_STREAM_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FB = 4 + PAR;

  logic       clk, rst_n;
  logic [7:0] a_sp, d_sp;
  logic [4:0] p_sp;
  logic       a_v, p_v, d_v;
  logic [1:0] a_lane, p_lane, d_lane;
  logic       a_fs, p_fs, d_fs, a_busy, p_busy, d_busy;
  logic [7:0] a_drop, p_drop, d_drop;

  int n_cmp = 0;
  int n_err = 0;

  snn_spike_streamer #(.N_SPIKES(8), .LANES(2), .DIV(1)) u_a (
    .clk(clk), .rst_n(rst_n), .spikes_in(a_sp), .spikes_valid(a_v),
    .lane_out(a_lane), .frame_sync(a_fs), .busy(a_busy), .drop_count(a_drop));

  snn_spike_streamer #(.N_SPIKES(5), .LANES(2), .DIV(1)) u_p (
    .clk(clk), .rst_n(rst_n), .spikes_in(p_sp), .spikes_valid(p_v),
    .lane_out(p_lane), .frame_sync(p_fs), .busy(p_busy), .drop_count(p_drop));

  snn_spike_streamer #(.N_SPIKES(8), .LANES(2), .DIV(3)) u_d (
    .clk(clk), .rst_n(rst_n), .spikes_in(d_sp), .spikes_valid(d_v),
    .lane_out(d_lane), .frame_sync(d_fs), .busy(d_busy), .drop_count(d_drop));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference beat: data beats take lane pairs LSB first, the optional last beat is per-lane XOR
  function automatic logic [1:0] exp_beat(input logic [7:0] vec, input int k, input int nsp);
    logic [15:0] mask;
    logic [7:0]  m;
    logic [1:0]  p;
    int          nb;
    nb   = (nsp + 1) / 2;
    mask = (16'd1 << nsp) - 16'd1;
    m    = vec & mask[7:0];
    if (k < nb) return 2'(m >> (2 * k));
    p = 2'b00;
    for (int j = 0; j < nb; j++) p = p ^ 2'(m >> (2 * j));
    return p;
  endfunction

  function automatic logic [11:0] obs(input int sel);
    case (sel)
      0:       return {a_drop, a_busy, a_fs, a_lane};
      1:       return {p_drop, p_busy, p_fs, p_lane};
      default: return {d_drop, d_busy, d_fs, d_lane};
    endcase
  endfunction

  task automatic check_frame(input int sel, input logic [7:0] vec, input int nsp,
                             input int div, input string tag);
    logic [11:0] o;
    int nb;
    nb = (nsp + 1) / 2 + PAR;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        o = obs(sel);
        chk($sformatf("%s lane b%0d c%0d", tag, k, c), 32'(o[1:0]), 32'(exp_beat(vec, k, nsp)));
        chk($sformatf("%s sync b%0d c%0d", tag, k, c), 32'(o[2]), (k == 0) ? 32'd1 : 32'd0);
        chk($sformatf("%s busy b%0d c%0d", tag, k, c), 32'(o[3]), 32'd1);
      end
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    logic [11:0] o;
    @(negedge clk);
    o = obs(sel);
    chk({tag, " idle busy"}, 32'(o[3]), 32'd0);
    chk({tag, " idle sync"}, 32'(o[2]), 32'd0);
    chk({tag, " idle lane"}, 32'(o[1:0]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_sp = '0; p_sp = '0; d_sp = '0;
    a_v = 1'b0; p_v = 1'b0; d_v = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) chk($sformatf("reset state dut%0d", s), 32'(obs(s)), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, "post-reset");

    // Single frame 8'hB4 -> 00,01,11,10
    a_sp = 8'hB4; a_v = 1'b1;
    fork
      begin @(negedge clk); a_v = 1'b0; end
      check_frame(0, 8'hB4, 8, 1, "single");
    join
    check_idle(0, "single");

    // Padding: 5'b10111 -> 11,01,01
    p_sp = 5'b10111; p_v = 1'b1;
    fork
      begin @(negedge clk); p_v = 1'b0; end
      check_frame(1, 8'h17, 5, 1, "pad");
    join
    check_idle(1, "pad");

    // Back-to-back: 0F, F0 pending, AA dropped while pending is full
    a_sp = 8'h0F; a_v = 1'b1;
    fork
      begin
        @(negedge clk); a_sp = 8'hF0;
        @(negedge clk); a_v = 1'b0;
        @(negedge clk); a_sp = 8'hAA; a_v = 1'b1;
        @(negedge clk); a_v = 1'b0;
      end
      begin
        check_frame(0, 8'h0F, 8, 1, "b2b first");
        check_frame(0, 8'hF0, 8, 1, "b2b second");
        check_idle(0, "b2b");
      end
    join
    chk("b2b drop_count", 32'(a_drop), 32'd1);

    // Collision on the final beat cycle with pending full: nothing dropped
    a_sp = 8'h12; a_v = 1'b1;
    fork
      begin
        @(negedge clk); a_sp = 8'h34;
        @(negedge clk); a_v = 1'b0;
        repeat (FB - 2) @(negedge clk);
        a_sp = 8'h56; a_v = 1'b1;
        @(negedge clk); a_v = 1'b0;
      end
      begin
        check_frame(0, 8'h12, 8, 1, "coll first");
        check_frame(0, 8'h34, 8, 1, "coll pending");
        check_frame(0, 8'h56, 8, 1, "coll arrived");
        check_idle(0, "coll");
      end
    join
    chk("coll drop_count", 32'(a_drop), 32'd1);

    // Saturation: continuous valid drops well over 255 vectors
    a_sp = 8'hFF; a_v = 1'b1;
    repeat (420) @(negedge clk);
    chk("sat drop_count", 32'(a_drop), 32'd255);
    chk("sat busy", 32'(a_busy), 32'd1);

    // Asynchronous reset mid-frame clears outputs without a clock edge
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst lane", 32'(a_lane), 32'd0);
    chk("async rst sync", 32'(a_fs), 32'd0);
    chk("async rst busy", 32'(a_busy), 32'd0);
    chk("async rst drop", 32'(a_drop), 32'd0);
    a_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_sp = 8'hB4; a_v = 1'b1;
    fork
      begin @(negedge clk); a_v = 1'b0; end
      check_frame(0, 8'hB4, 8, 1, "after rst");
    join
    check_idle(0, "after rst");

    // DIV=3: every beat held three cycles
    d_sp = 8'hB4; d_v = 1'b1;
    fork
      begin @(negedge clk); d_v = 1'b0; end
      check_frame(2, 8'hB4, 8, 3, "div3");
    join
    check_idle(2, "div3");
    chk("div3 drop_count", 32'(d_drop), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
